// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I multi-cycle datapath
module multicycle_control_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W = 8,
  parameter int RET_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       OpCode,
  input  logic [2:0]       Funct3,
  input  logic [6:0]       Funct7,
  input  logic             IMReady,
  input  logic             DMReady,
  output logic             IMReq,
  output logic             IRWr,
  output logic             DMReq,
  output logic             DMWr,
  output logic [2:0]       DMCtrl,
  output logic             RUWr,
  output logic [1:0]       RUDataWrSrc,
  output logic             AlUASrc,
  output logic             AlUBSrc,
  output logic [2:0]       ImmSrc,
  output logic [3:0]       ALUOp,
  output logic [4:0]       BrOp,
  output logic             PCWr,
  output logic             Fault,
  output logic [1:0]       FaultCause,
  output logic [RET_W-1:0] InstRet,
  output logic [2:0]       State
);
  typedef enum logic [2:0] {
    FETCH  = 3'b000,
    DECODE = 3'b001,
    EXEC   = 3'b010,
    MEM    = 3'b011,
    WB     = 3'b100,
    TRAP   = 3'b111
  } state_t;
  state_t state, next_state;
  logic [TO_W-1:0] cnt, next_cnt, cnt_inc;
  logic [1:0] cause, next_cause;
  logic [RET_W-1:0] ret;
  logic im_req, ir_wr, dm_req, dm_wr, ru_wr, pc_wr, expired;
  logic is_op, is_opi, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic opcode_ok, f3_ok, shift_ok, legal;
  assign is_op    = OpCode == 7'b0110011;
  assign is_opi   = OpCode == 7'b0010011;
  assign is_ld    = OpCode == 7'b0000011;
  assign is_st    = OpCode == 7'b0100011;
  assign is_br    = OpCode == 7'b1100011;
  assign is_jal   = OpCode == 7'b1101111;
  assign is_jalr  = OpCode == 7'b1100111;
  assign is_lui   = OpCode == 7'b0110111;
  assign is_auipc = OpCode == 7'b0010111;
  assign opcode_ok = is_op | is_opi | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;
  assign f3_ok = is_ld ? (Funct3 != 3'b011 && Funct3 != 3'b110 && Funct3 != 3'b111) :
                 is_st ? (Funct3 <= 3'b010) :
                 is_br ? (Funct3[2:1] != 2'b01) :
                 is_jalr ? (Funct3 == 3'b000) : 1'b1;
  assign shift_ok = !(is_opi && Funct3[1:0] == 2'b01) || Funct7 == 7'b0000000 ||
                    (Funct3 == 3'b101 && Funct7 == 7'b0100000);
  assign legal = opcode_ok && f3_ok && shift_ok;
  assign AlUASrc = is_br | is_jal | is_auipc;
  assign AlUBSrc = !is_op;
  assign ALUOp = is_op ? {Funct7[5], Funct3} :
                 is_opi ? {Funct3 == 3'b101 && Funct7[5], Funct3} : 4'b0000;
  assign BrOp = {is_jal | is_jalr, is_br | is_jal | is_jalr, Funct3};
  assign RUDataWrSrc = is_ld ? 2'b01 : (is_jal | is_jalr) ? 2'b10 : 2'b00;
  assign ImmSrc = is_st ? 3'b001 :
                  (is_lui | is_auipc) ? 3'b010 :
                  is_br ? 3'b101 :
                  is_jal ? 3'b110 : 3'b000;
  assign DMCtrl = Funct3;
  assign cnt_inc = cnt + TO_W'(1);
  assign expired = TIMEOUT_CYCLES != 0 && cnt_inc == TO_W'(TIMEOUT_CYCLES);
  // next-state, wait counter, fault cause and raw strobes; a ready always beats the timeout
  always_comb begin
    next_state = state;
    next_cnt = '0;
    next_cause = cause;
    im_req = 1'b0;
    ir_wr = 1'b0;
    dm_req = 1'b0;
    dm_wr = 1'b0;
    ru_wr = 1'b0;
    pc_wr = 1'b0;
    case (state)
      FETCH: begin
        im_req = 1'b1;
        if (IMReady) begin
          ir_wr = 1'b1;
          next_state = DECODE;
        end else if (expired) begin
          next_state = TRAP;
          next_cause = 2'b10;
        end else next_cnt = cnt_inc;
      end
      DECODE: begin
        next_state = legal ? EXEC : TRAP;
        next_cause = legal ? cause : 2'b01;
      end
      EXEC: begin
        pc_wr = is_br;
        next_state = (is_ld | is_st) ? MEM : is_br ? FETCH : WB;
      end
      MEM: begin
        dm_req = 1'b1;
        dm_wr = is_st;
        if (DMReady) begin
          pc_wr = is_st;
          next_state = is_st ? FETCH : WB;
        end else if (expired) begin
          next_state = TRAP;
          next_cause = 2'b11;
        end else next_cnt = cnt_inc;
      end
      WB: begin
        ru_wr = 1'b1;
        pc_wr = 1'b1;
        next_state = FETCH;
      end
      TRAP: next_state = TRAP;
      default: next_state = FETCH;
    endcase
  end
  assign IMReq = im_req & ~rst;
  assign IRWr  = ir_wr & ~rst;
  assign DMReq = dm_req & ~rst;
  assign DMWr  = dm_wr & ~rst;
  assign RUWr  = ru_wr & ~rst;
  assign PCWr  = pc_wr & ~rst;
  assign Fault = state == TRAP;
  assign FaultCause = cause;
  assign InstRet = ret;
  assign State = state;
  // state, wait counter, fault cause and retire counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      cnt <= '0;
      cause <= 2'b00;
      ret <= '0;
    end else begin
      state <= next_state;
      cnt <= next_cnt;
      cause <= next_cause;
      ret <= ret + RET_W'(PCWr);
    end
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle RV32I decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB using ready handshakes to instruction and data memory.
- Gates every architectural write enable to the correct phase, detects illegal encodings and memory timeouts, and counts retired instructions.
- Sits between the datapath (PC, IR, register unit, ALU, branch unit) and the memory ports.

Parameters:
- TIMEOUT_CYCLES, 255: maximum wait cycles for IMReady/DMReady before a fault; 0 disables the timeout.
- TO_W, 8: width of the wait counter; must hold TIMEOUT_CYCLES.
- RET_W, 32: width of the InstRet counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- OpCode  in  7  IR[6:0], valid from DECODE onward
- Funct3  in  3  IR[14:12]
- Funct7  in  7  IR[31:25]
- IMReady  in  1  instruction memory data valid
- DMReady  in  1  data memory access complete
- IMReq  out  1  instruction fetch request
- IRWr  out  1  latch instruction register
- DMReq  out  1  data memory request
- DMWr  out  1  data memory write strobe
- DMCtrl  out  3  access size/sign (= Funct3)
- RUWr  out  1  register unit write
- RUDataWrSrc  out  2  writeback source: 00 ALU, 01 memory, 10 PC+4
- AlUASrc  out  1  0 = rs1, 1 = PC
- AlUBSrc  out  1  0 = rs2, 1 = immediate
- ImmSrc  out  3  immediate format: I 000, S 001, U 010, B 101, J 110
- ALUOp  out  4  ALU operation
- BrOp  out  5  branch unit control
- PCWr  out  1  PC update (selection by BrOp)
- Fault  out  1  sticky fault flag
- FaultCause  out  2  00 none, 01 illegal instruction, 10 IM timeout, 11 DM timeout
- InstRet  out  RET_W  retired-instruction count
- State  out  3  current state, for debug

Behaviour:
- Reset: rst sampled on a rising clk.
  - State = FETCH; Fault = 0; FaultCause = 00; InstRet = 0; wait counter = 0.
  - All strobes (IMReq, IRWr, DMReq, DMWr, RUWr, PCWr) = 0 in the reset cycle.
  - rst overrides every state, including TRAP and mid-handshake waits; any pending memory request is simply dropped.
- State encoding: FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100, TRAP 111.
- Decode outputs are combinational from OpCode/Funct3/Funct7 in every state (only strobes are gated):
  - AlUASrc = 1 for branch, JAL, AUIPC; 0 otherwise.
  - AlUBSrc = 0 only for OP (0110011).
  - ALUOp:
    - OP: {Funct7[5], Funct3}.
    - OP-IMM: {Funct3 == 101 ? Funct7[5] : 0, Funct3}.
    - All other opcodes: 0000.
  - BrOp = {JAL|JALR, branch|JAL|JALR, Funct3}.
  - RUDataWrSrc: load = 01; JAL/JALR = 10; otherwise 00.
  - DMCtrl = Funct3.
- FETCH:
  - IMReq = 1.
  - On IMReady: IRWr = 1 for one cycle, go to DECODE, clear the counter.
  - Otherwise increment the counter. Reaching TIMEOUT_CYCLES (nonzero) goes to TRAP with cause 10.
- DECODE: one cycle.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Legal Funct3:
    - Load: 000, 001, 010, 100, 101.
    - Store: 000–010.
    - Branch: any value except 010 and 011.
    - JALR: 000.
  - Shift (OP-IMM, Funct3 001/101): Funct7 must be 0000000, or 0100000 for 101 only.
  - Any violation goes to TRAP with cause 01.
  - Otherwise go to EXEC.
- EXEC: one cycle.
  - Load/store go to MEM.
  - Branch: PCWr = 1, InstRet + 1, go to FETCH.
  - All others go to WB.
- MEM:
  - DMReq = 1; DMWr = 1 for a store, held until DMReady.
  - DMReady while loading goes to WB.
  - DMReady while storing: PCWr = 1, InstRet + 1, go to FETCH.
  - Timeout is counted as in FETCH; on expiry go to TRAP with cause 11, and DMWr drops on entry.
- WB: one cycle. RUWr = 1, PCWr = 1, InstRet + 1, go to FETCH.
- TRAP:
  - All strobes = 0; Fault = 1; FaultCause is held.
  - Only rst exits TRAP.
- InstRet increments exactly once per PCWr pulse and wraps modulo 2^RET_W.
- Strobe exclusivity: RUWr, DMWr and PCWr are never asserted outside WB, MEM and the retire cycles listed above.
- Ready timing:
  - IMReady/DMReady are ignored outside FETCH/MEM.
  - A ready arriving in the same cycle the counter reaches the limit wins; no fault is raised.
- Latency:
  - ALU op / JAL / LUI: 4 cycles.
  - Branch: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Each figure is with zero-wait memory (ready in the first cycle of the phase).

Test Plan:
- add x3,x1,x2 (0x002081B3), IMReady immediate → IRWr in cycle 1; RUWr and PCWr in cycle 4 with ALUOp 0000, AlUBSrc 0; InstRet 0→1.
- sub (Funct7 0100000) then srai (OP-IMM, Funct3 101, Funct7 0100000) → ALUOp 1000 then 1101; srli → 0101; slli with Funct7 0100000 → TRAP, cause 01.
- lw with DMReady delayed 3 cycles → DMReq held 4 cycles with DMWr 0; RUDataWrSrc 01; RUWr in WB; total 8 cycles.
- sw → DMWr 1 only while in MEM; PCWr on the DMReady cycle; RUWr never asserted.
- beq → BrOp 01000, ImmSrc 101, PCWr in cycle 3; OpCode 1110011 → TRAP, Fault 1, no strobes until rst.
- TIMEOUT_CYCLES=4, IMReady held low → TRAP after 4 wait cycles with cause 10; rst asserted in TRAP → State 000, Fault 0, InstRet 0 the next cycle.
